regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Sequencer and arbiter in front of `register_file`. Zero-initialises all 32 registers after reset, then shares the single read-or-write-per-cycle register file port among three requesters: writeback (writes), decode (dual-operand reads) and debug (single-register read/write). Generates all `register_file` control inputs and returns read data with a requester tag. Never asserts read and write in the same cycle.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive blocked cycles after which a pending debug request outranks decode; range 1..15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wb_valid`  in  1  writeback write request.
- `wb_ready`  out  1  writeback granted this cycle.
- `wb_rdId`  in  5  destination register.
- `wb_rd`  in  32  write data.
- `dec_valid`  in  1  decode read request.
- `dec_ready`  out  1  decode granted this cycle.
- `dec_rs1Id`  in  5  first source register.
- `dec_rs2Id`  in  5  second source register.
- `dbg_valid`  in  1  debug request.
- `dbg_ready`  out  1  debug granted this cycle.
- `dbg_we`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  5  register index.
- `dbg_wdata`  in  32  debug write data.
- `rsp_valid`  out  1  read data valid.
- `rsp_dbg`  out  1  0 = response belongs to decode, 1 = response belongs to debug.
- `rsp_rs1`  out  32  first operand, or debug read data.
- `rsp_rs2`  out  32  second operand; debug reads leave it unspecified.
- `init_done`  out  1  clear sequence complete.
- `rf_read`, `rf_write`  out  1 each  to `register_file` `read`/`write`.
- `rf_rs1Id`, `rf_rs2Id`, `rf_rdId`  out  5 each  to `register_file`.
- `rf_rd`  out  32  to `register_file` `rd`.
- `rf_rs1`, `rf_rs2`  in  32 each  from `register_file` `rs1`/`rs2`.

## Operation
- States:
  - CLEAR, entered on reset: 5-bit index `clr_idx` runs 0..31. Each cycle asserts `rf_write=1`, `rf_rdId=clr_idx`, `rf_rd=0`. After index 31 is written, the block moves to RUN and sets `init_done=1`. All readies stay 0 in CLEAR.
  - RUN: one grant per cycle. Priority order, highest first:
    1. writeback;
    2. debug, if `starve_cnt >= STARVE_LIMIT`;
    3. decode;
    4. debug.
- Grant actions:
  - Writeback grant: `rf_write=1`, `rf_rdId=wb_rdId`, `rf_rd=wb_rd`.
  - Decode grant: `rf_read=1`, `rf_rs1Id=dec_rs1Id`, `rf_rs2Id=dec_rs2Id`.
  - Debug write: behaves as a writeback grant, using `dbg_addr`/`dbg_wdata`.
  - Debug read: `rf_read=1`, `rf_rs1Id=rf_rs2Id=dbg_addr`.
- x0 protection: any write with destination 0 is accepted (ready=1) but forces `rf_write=0`. x0 therefore stays 0 after CLEAR.
- `starve_cnt` (4 bits):
  - +1 each RUN cycle with `dbg_valid && !dbg_ready`, saturating at `STARVE_LIMIT`;
  - cleared on a debug grant;
  - cleared when `dbg_valid=0`.
- A read and a write on the same register in the same cycle are resolved by priority. The write goes first; the read is granted on a later cycle and returns the new value. No bypass.
- Request fields must be held stable while valid is high and ready is low.

## Timing
- Grants are combinational from the state and the current valids. Ready and `rf_*` change within the cycle; the register file samples them at the next edge.
- Read latency: a read granted in cycle N has `rsp_valid=1` in cycle N+1, with `rsp_rs1/rsp_rs2` driven combinationally from `rf_rs1/rf_rs2`. `rsp_valid` is high for exactly one cycle per read grant. Back-to-back reads give back-to-back responses.
- `rsp_dbg` is registered alongside `rsp_valid`.
- CLEAR lasts exactly 32 cycles after `rst` deasserts. `init_done` rises in the cycle after the write of index 31, which is the first RUN cycle.
- Reset values:
  - `wb_ready`, `dec_ready`, `dbg_ready`, `rsp_valid`, `rsp_dbg`, `init_done` = 0;
  - `rf_read`, `rf_write` = 0 while `rst` is high;
  - `rf_*Id` = 0, `rf_rd` = 0;
  - `clr_idx` = 0, `starve_cnt` = 0.
- Reset asserted mid-operation, including mid-CLEAR or with a response pending: the block returns to CLEAR immediately, the pending response is dropped (`rsp_valid=0`), and it restarts at index 0.
- The block never drives `rf_read` and `rf_write` high together.

## Test plan
- Reset release: exactly 32 writes of 0 to r0..r31 in order, all readies 0 meanwhile, `init_done=1` on cycle 33.
- Writeback r5=0x1234_5678, then decode rs1=5, rs2=0: response one cycle after `dec_ready` carries `rsp_rs1=0x12345678`, `rsp_rs2=0`, `rsp_dbg=0`.
- Same-cycle writeback r7=0xA5A5A5A5 and decode rs1=7: `wb_ready=1`, `dec_ready=0`; decode is granted next cycle and returns 0xA5A5A5A5.
- Writeback to r0 with data 0xFFFF_FFFF: `wb_ready=1`, `rf_write=0`; a later read of r0 returns 0.
- Decode valid every cycle with a debug read of r3 pending, `STARVE_LIMIT=4`: debug is granted on its 5th pending cycle and gets a response with `rsp_dbg=1`; `starve_cnt` returns to 0.
- `rst` pulsed mid-CLEAR at index 10 and again with a read response pending: `rsp_valid=0` immediately, and CLEAR restarts at index 0 for a full 32 cycles.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Sequencer and arbiter in front of a single-port register file: clears all 32
// registers after reset, then grants writeback, decode or debug one per cycle.
module regfile_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rdId,
    input  logic [31:0] wb_rd,

    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [4:0]  dec_rs1Id,
    input  logic [4:0]  dec_rs2Id,

    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,

    output logic        rsp_valid,
    output logic        rsp_dbg,
    output logic [31:0] rsp_rs1,
    output logic [31:0] rsp_rs2,
    output logic        init_done,

    output logic        rf_read,
    output logic        rf_write,
    output logic [4:0]  rf_rs1Id,
    output logic [4:0]  rf_rs2Id,
    output logic [4:0]  rf_rdId,
    output logic [31:0] rf_rd,
    input  logic [31:0] rf_rs1,
    input  logic [31:0] rf_rs2
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    typedef enum logic [1:0] {
        G_NONE,
        G_WB,
        G_DEC,
        G_DBG
    } grant_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_dbg_q, rsp_dbg_d;
    grant_e     grant;

    // Grant selection and register-file drive; writes to x0 are accepted but dropped.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant     = G_NONE;
        rf_read   = 1'b0;
        rf_write  = 1'b0;
        rf_rs1Id  = '0;
        rf_rs2Id  = '0;
        rf_rdId   = '0;
        rf_rd     = '0;

        if (state_q == S_RUN) begin
            if (wb_valid)                              grant = G_WB;
            else if (dbg_valid && starve_cnt_q >= LIMIT) grant = G_DBG;
            else if (dec_valid)                        grant = G_DEC;
            else if (dbg_valid)                        grant = G_DBG;
        end

        case (grant)
            G_NONE: begin
                if (state_q == S_CLEAR) begin
                    rf_write = !rst;
                    rf_rdId  = clr_idx_q;
                end
            end
            G_WB: begin
                rf_write = (wb_rdId != 5'd0);
                rf_rdId  = wb_rdId;
                rf_rd    = wb_rd;
            end
            G_DEC: begin
                rf_read  = 1'b1;
                rf_rs1Id = dec_rs1Id;
                rf_rs2Id = dec_rs2Id;
            end
            G_DBG: begin
                if (dbg_we) begin
                    rf_write = (dbg_addr != 5'd0);
                    rf_rdId  = dbg_addr;
                    rf_rd    = dbg_wdata;
                end else begin
                    rf_read  = 1'b1;
                    rf_rs1Id = dbg_addr;
                    rf_rs2Id = dbg_addr;
                end
            end
            default: ;
        endcase
    end

    assign wb_ready  = (grant == G_WB);
    assign dec_ready = (grant == G_DEC);
    assign dbg_ready = (grant == G_DBG);

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        starve_cnt_d = starve_cnt_q;
        rsp_valid_d  = rf_read;
        rsp_dbg_d    = rf_read && (grant == G_DBG);

        case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) state_d = S_RUN;
            end
            S_RUN: begin
                // Counts consecutive blocked debug cycles; saturates at the limit.
                if (!dbg_valid || grant == G_DBG)  starve_cnt_d = '0;
                else if (starve_cnt_q < LIMIT)     starve_cnt_d = starve_cnt_q + 4'd1;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clr_idx_q    <= '0;
            starve_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dbg_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dbg_q    <= rsp_dbg_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_dbg   = rsp_dbg_q;
    assign rsp_rs1   = rf_rs1;
    assign rsp_rs2   = rf_rs2;
    assign init_done = (state_q == S_RUN);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios plus a randomized
// run checked against a register-array model of the arbitration rules.
module tb_regfile_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef enum int {G_NONE, G_WB, G_DEC, G_DBG} grant_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rdId;
    logic [31:0] wb_rd;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rs1Id, dec_rs2Id;
    logic        dbg_valid, dbg_ready, dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        rsp_valid, rsp_dbg, init_done;
    logic [31:0] rsp_rs1, rsp_rs2;
    logic        rf_read, rf_write;
    logic [4:0]  rf_rs1Id, rf_rs2Id, rf_rdId;
    logic [31:0] rf_rd, rf_rs1, rf_rs2;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf_mem  [32];
    logic [31:0] ref_mem [32];
    int          m_starve;
    logic        exp_rsp_valid, exp_rsp_dbg;
    logic [31:0] exp_rs1, exp_rs2;

    regfile_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdId(wb_rdId), .wb_rd(wb_rd),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_rs1Id(dec_rs1Id), .dec_rs2Id(dec_rs2Id),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .rsp_valid(rsp_valid), .rsp_dbg(rsp_dbg), .rsp_rs1(rsp_rs1), .rsp_rs2(rsp_rs2),
        .init_done(init_done),
        .rf_read(rf_read), .rf_write(rf_write), .rf_rs1Id(rf_rs1Id), .rf_rs2Id(rf_rs2Id),
        .rf_rdId(rf_rdId), .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2)
    );

    always #5 clk = ~clk;

    // Register file stand-in with registered read data; scrambled while in reset
    // so that only the clear sequence can make it read back zero.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= $urandom;
        end else begin
            if (rf_write) rf_mem[rf_rdId] <= rf_rd;
            if (rf_read) begin
                rf_rs1 <= rf_mem[rf_rs1Id];
                rf_rs2 <= rf_mem[rf_rs2Id];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        m_starve      = 0;
        exp_rsp_valid = 1'b0;
        exp_rsp_dbg   = 1'b0;
        exp_rs1       = '0;
        exp_rs2       = '0;
    endfunction

    function automatic grant_e model_grant();
        if (wb_valid)                            return G_WB;
        if (dbg_valid && m_starve >= STARVE_LIMIT) return G_DBG;
        if (dec_valid)                           return G_DEC;
        if (dbg_valid)                           return G_DBG;
        return G_NONE;
    endfunction

    function automatic void model_commit(input grant_e g);
        exp_rsp_valid = (g == G_DEC) || (g == G_DBG && !dbg_we);
        exp_rsp_dbg   = (g == G_DBG);
        exp_rs1       = (g == G_DEC) ? ref_mem[dec_rs1Id] : ref_mem[dbg_addr];
        exp_rs2       = ref_mem[dec_rs2Id];
        if (g == G_WB && wb_rdId != 0)                ref_mem[wb_rdId]  = wb_rd;
        if (g == G_DBG && dbg_we && dbg_addr != 0)    ref_mem[dbg_addr] = dbg_wdata;
        m_starve = (dbg_valid && g != G_DBG) ? m_starve + 1 : 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        wb_valid = 0; dec_valid = 0; dbg_valid = 0; dbg_we = 0;
        wb_rdId = '0; wb_rd = '0; dec_rs1Id = '0; dec_rs2Id = '0;
        dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Releases reset and follows the clear sequence; stop_at < 32 re-asserts
    // reset during the cycle that writes that index.
    task automatic run_clear(input int stop_at);
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            wb_valid = 1; dec_valid = 1; dbg_valid = 1;
            dbg_we = 1'($urandom_range(0, 1));
            wb_rdId = 5'($urandom); wb_rd = $urandom;
            dec_rs1Id = 5'($urandom); dec_rs2Id = 5'($urandom);
            dbg_addr = 5'($urandom); dbg_wdata = $urandom;
            @(negedge clk);
            checks++;
            if ({rf_write, rf_read} !== 2'b10 || rf_rdId !== 5'(i) || rf_rd !== 32'h0) begin
                errors++;
                $display("FAIL clear_write idx %0d: got write=%b read=%b rdId=%0d rd=%h, expected 1 0 %0d 0",
                         i, rf_write, rf_read, rf_rdId, rf_rd, i);
            end
            checks++;
            if ({wb_ready, dec_ready, dbg_ready, init_done} !== 4'b0000) begin
                errors++;
                $display("FAIL clear_ready idx %0d: got wb/dec/dbg/init=%b, expected 0000",
                         i, {wb_ready, dec_ready, dbg_ready, init_done});
            end
            if (i == stop_at) begin
                rst = 1;
                #1;
                checks++;
                if ({rf_write, rf_read} !== 2'b00 || rf_rdId !== 5'd0 || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_clear: got write=%b read=%b rdId=%0d rsp_valid=%b, expected 0 0 0 0",
                             rf_write, rf_read, rf_rdId, rsp_valid);
                end
                drive_idle();
                return;
            end
            tick();
        end
        drive_idle();
        model_reset();
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || rf_write !== 1'b0 || rf_read !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: got init_done=%b write=%b read=%b, expected 1 0 0",
                     init_done, rf_write, rf_read);
        end
        model_commit(model_grant());
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_ready, dec_ready, dbg_ready, rsp_valid, rsp_dbg, init_done, rf_read, rf_write} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 00000000",
                     {wb_ready, dec_ready, dbg_ready, rsp_valid, rsp_dbg, init_done, rf_read, rf_write});
        end
        checks++;
        if ({rf_rs1Id, rf_rs2Id, rf_rdId} !== 15'b0 || rf_rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_fields: got rs1Id=%0d rs2Id=%0d rdId=%0d rd=%h, expected all 0",
                     rf_rs1Id, rf_rs2Id, rf_rdId, rf_rd);
        end
        run_clear(32);
    endtask

    task automatic test_wb_then_dec();
        grant_e g;
        drive_idle();
        wb_valid = 1; wb_rdId = 5'd5; wb_rd = 32'h1234_5678;
        @(negedge clk);
        g = model_grant();
        checks++;
        if ({wb_ready, dec_ready, dbg_ready, rf_write, rf_read} !== 5'b10010 ||
            rf_rdId !== 5'd5 || rf_rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wb_grant: got rdy=%b w/r=%b rdId=%0d rd=%h, expected 100 10 5 12345678",
                     {wb_ready, dec_ready, dbg_ready}, {rf_write, rf_read}, rf_rdId, rf_rd);
        end
        model_commit(g);
        tick();
        drive_idle();
        dec_valid = 1; dec_rs1Id = 5'd5; dec_rs2Id = 5'd0;
        @(negedge clk);
        g = model_grant();
        checks++;
        if ({wb_ready, dec_ready, dbg_ready, rf_write, rf_read} !== 5'b01001 ||
            rf_rs1Id !== 5'd5 || rf_rs2Id !== 5'd0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL dec_grant: got rdy=%b w/r=%b rs1Id=%0d rs2Id=%0d rsp_valid=%b, expected 010 01 5 0 0",
                     {wb_ready, dec_ready, dbg_ready}, {rf_write, rf_read}, rf_rs1Id, rf_rs2Id, rsp_valid);
        end
        model_commit(g);
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_dbg !== 1'b0 || rsp_rs1 !== 32'h1234_5678 || rsp_rs2 !== 32'h0) begin
            errors++;
            $display("FAIL dec_rsp: got valid=%b dbg=%b rs1=%h rs2=%h, expected 1 0 12345678 00000000",
                     rsp_valid, rsp_dbg, rsp_rs1, rsp_rs2);
        end
        model_commit(model_grant());
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_one_cycle: got rsp_valid=%b, expected 0", rsp_valid);
        end
        model_commit(model_grant());
        tick();
    endtask

    task automatic test_same_cycle();
        grant_e g;
        drive_idle();
        wb_valid = 1; wb_rdId = 5'd7; wb_rd = 32'hA5A5_A5A5;
        dec_valid = 1; dec_rs1Id = 5'd7; dec_rs2Id = 5'd5;
        @(negedge clk);
        g = model_grant();
        checks++;
        if ({wb_ready, dec_ready, rf_write, rf_read} !== 4'b1010) begin
            errors++;
            $display("FAIL same_cycle_wb: got wb/dec=%b w/r=%b, expected 10 10",
                     {wb_ready, dec_ready}, {rf_write, rf_read});
        end
        model_commit(g);
        tick();
        wb_valid = 0;
        @(negedge clk);
        g = model_grant();
        checks++;
        if (dec_ready !== 1'b1 || rf_read !== 1'b1 || rf_rs1Id !== 5'd7) begin
            errors++;
            $display("FAIL same_cycle_dec: got dec_ready=%b read=%b rs1Id=%0d, expected 1 1 7",
                     dec_ready, rf_read, rf_rs1Id);
        end
        model_commit(g);
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1 !== 32'hA5A5_A5A5 || rsp_rs2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL same_cycle_rsp: got valid=%b rs1=%h rs2=%h, expected 1 a5a5a5a5 12345678",
                     rsp_valid, rsp_rs1, rsp_rs2);
        end
        model_commit(model_grant());
        tick();
    endtask

    task automatic test_x0();
        grant_e g;
        drive_idle();
        wb_valid = 1; wb_rdId = 5'd0; wb_rd = 32'hFFFF_FFFF;
        @(negedge clk);
        g = model_grant();
        checks++;
        if (wb_ready !== 1'b1 || rf_write !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: got wb_ready=%b rf_write=%b, expected 1 0", wb_ready, rf_write);
        end
        model_commit(g);
        tick();
        drive_idle();
        dec_valid = 1; dec_rs1Id = 5'd0; dec_rs2Id = 5'd0;
        @(negedge clk);
        model_commit(model_grant());
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1 !== 32'h0 || rsp_rs2 !== 32'h0) begin
            errors++;
            $display("FAIL x0_read: got valid=%b rs1=%h rs2=%h, expected 1 0 0", rsp_valid, rsp_rs1, rsp_rs2);
        end
        model_commit(model_grant());
        tick();
    endtask

    task automatic test_starvation();
        grant_e g;
        int got;
        drive_idle();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 5'd3; dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        g = model_grant();
        checks++;
        if (dbg_ready !== 1'b1 || rf_write !== 1'b1 || rf_rdId !== 5'd3 || rf_rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dbg_write: got ready=%b write=%b rdId=%0d rd=%h, expected 1 1 3 deadbeef",
                     dbg_ready, rf_write, rf_rdId, rf_rd);
        end
        model_commit(g);
        tick();
        for (int round = 0; round < 2; round++) begin
            got = 0;
            drive_idle();
            dbg_valid = 1; dbg_we = 0; dbg_addr = 5'd3;
            for (int c = 1; c <= 10 && got == 0; c++) begin
                dec_valid = 1; dec_rs1Id = 5'($urandom); dec_rs2Id = 5'($urandom);
                @(negedge clk);
                g = model_grant();
                checks++;
                if (dec_ready !== ~dbg_ready) begin
                    errors++;
                    $display("FAIL starve_exclusive: got dec_ready=%b dbg_ready=%b, expected exactly one",
                             dec_ready, dbg_ready);
                end
                if (dbg_ready === 1'b1) begin
                    got = c;
                    checks++;
                    if (rf_read !== 1'b1 || rf_rs1Id !== 5'd3 || rf_rs2Id !== 5'd3) begin
                        errors++;
                        $display("FAIL dbg_read_ids: got read=%b rs1Id=%0d rs2Id=%0d, expected 1 3 3",
                                 rf_read, rf_rs1Id, rf_rs2Id);
                    end
                end
                model_commit(g);
                tick();
            end
            checks++;
            if (got != STARVE_LIMIT + 1) begin
                errors++;
                $display("FAIL starve_grant round %0d: granted on pending cycle %0d, expected %0d",
                         round, got, STARVE_LIMIT + 1);
            end
            drive_idle();
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_dbg !== 1'b1 || rsp_rs1 !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL dbg_rsp round %0d: got valid=%b dbg=%b rs1=%h, expected 1 1 deadbeef",
                         round, rsp_valid, rsp_dbg, rsp_rs1);
            end
            model_commit(model_grant());
            tick();
        end
    endtask

    task automatic test_random();
        grant_e g;
        logic   wb_hold, dec_hold, dbg_hold, exp_w, exp_r;
        wb_hold = 0; dec_hold = 0; dbg_hold = 0;
        drive_idle();
        for (int n = 0; n < 400; n++) begin
            if (!wb_hold) begin
                wb_valid = ($urandom_range(0, 3) == 0);
                wb_rdId = 5'($urandom); wb_rd = $urandom;
            end
            if (!dec_hold) begin
                dec_valid = 1'($urandom_range(0, 1));
                dec_rs1Id = 5'($urandom); dec_rs2Id = 5'($urandom);
            end
            if (!dbg_hold) begin
                dbg_valid = ($urandom_range(0, 2) == 0);
                dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 5'($urandom); dbg_wdata = $urandom;
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== exp_rsp_valid) begin
                errors++;
                $display("FAIL rnd_rsp_valid cycle %0d: got %b, expected %b", n, rsp_valid, exp_rsp_valid);
            end else if (exp_rsp_valid && (rsp_dbg !== exp_rsp_dbg || rsp_rs1 !== exp_rs1 ||
                                           (!exp_rsp_dbg && rsp_rs2 !== exp_rs2))) begin
                errors++;
                $display("FAIL rnd_rsp_data cycle %0d: got dbg=%b rs1=%h rs2=%h, expected %b %h %h",
                         n, rsp_dbg, rsp_rs1, rsp_rs2, exp_rsp_dbg, exp_rs1, exp_rs2);
            end
            g = model_grant();
            checks++;
            if ({wb_ready, dec_ready, dbg_ready} !== {g == G_WB, g == G_DEC, g == G_DBG}) begin
                errors++;
                $display("FAIL rnd_grant cycle %0d: got wb/dec/dbg=%b, expected %b", n,
                         {wb_ready, dec_ready, dbg_ready}, {g == G_WB, g == G_DEC, g == G_DBG});
            end
            exp_w = (g == G_WB && wb_rdId != 0) || (g == G_DBG && dbg_we && dbg_addr != 0);
            exp_r = (g == G_DEC) || (g == G_DBG && !dbg_we);
            checks++;
            if ({rf_write, rf_read} !== {exp_w, exp_r}) begin
                errors++;
                $display("FAIL rnd_rf_ctrl cycle %0d: got write/read=%b, expected %b", n,
                         {rf_write, rf_read}, {exp_w, exp_r});
            end
            wb_hold  = wb_valid && g != G_WB;
            dec_hold = dec_valid && g != G_DEC;
            dbg_hold = dbg_valid && g != G_DBG;
            model_commit(g);
            tick();
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== exp_rsp_valid ||
            (exp_rsp_valid && (rsp_rs1 !== exp_rs1 || rsp_dbg !== exp_rsp_dbg))) begin
            errors++;
            $display("FAIL rnd_drain: got valid=%b dbg=%b rs1=%h, expected %b %b %h",
                     rsp_valid, rsp_dbg, rsp_rs1, exp_rsp_valid, exp_rsp_dbg, exp_rs1);
        end
        model_commit(model_grant());
        tick();
    endtask

    task automatic test_reset_mid_response();
        drive_idle();
        dbg_valid = 1; dbg_we = 0; dbg_addr = 5'd3;
        @(negedge clk);
        model_commit(model_grant());
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_dbg !== 1'b1) begin
            errors++;
            $display("FAIL pending_rsp: got valid=%b dbg=%b, expected 1 1", rsp_valid, rsp_dbg);
        end
        rst = 1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_dbg !== 1'b0 || init_done !== 1'b0 || rf_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_rsp: got valid=%b dbg=%b init=%b read=%b, expected 0 0 0 0",
                     rsp_valid, rsp_dbg, init_done, rf_read);
        end
        run_clear(32);
    endtask

    task automatic test_reset_mid_clear();
        drive_idle();
        rst = 1;
        tick();
        run_clear(10);
        run_clear(32);
        drive_idle();
        dec_valid = 1; dec_rs1Id = 5'd3; dec_rs2Id = 5'd7;
        @(negedge clk);
        model_commit(model_grant());
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rs1 !== 32'h0 || rsp_rs2 !== 32'h0) begin
            errors++;
            $display("FAIL post_clear_read: got valid=%b rs1=%h rs2=%h, expected 1 0 0",
                     rsp_valid, rsp_rs1, rsp_rs2);
        end
        model_commit(model_grant());
        tick();
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_wb_then_dec();
        test_same_cycle();
        test_x0();
        test_starvation();
        test_random();
        test_reset_mid_response();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
